// File: rtl/uart_mon_mem_engine_if.sv
// Monitor engine bus: decoder commands, RAM ports and sender handshake.
// MON_DUMP_ADR_EN adds snd_adr, the byte address of each dump line.
interface uart_mon_mem_engine_if #(
  parameter int ADR_W  = 10,
  parameter int NCH    = 2,
  parameter int CH_W   = 1,
  parameter int LINE_W = 2
);
  logic [31:0]          cmd_data;
  logic [CH_W-1:0]      cmd_ch;
  logic                 wadr_set;
  logic                 wdata_en;
  logic                 rd_start_set;
  logic                 rd_end_set;
  logic                 rd_stop;
  logic [ADR_W-1:0]     ram_radr;
  logic [NCH*32-1:0]    ram_rdata;
  logic [ADR_W-1:0]     ram_wadr;
  logic [31:0]          ram_wdata;
  logic [NCH-1:0]       ram_wen;
  logic [NCH-1:0]       read_sel;
  logic [LINE_W*32-1:0] snd_data;
  logic                 snd_start;
  logic                 snd_busy;
  logic                 dump_running;
`ifdef MON_DUMP_ADR_EN
  logic [ADR_W+1:0]     snd_adr;
`endif

  modport master (
    output cmd_data, cmd_ch, wadr_set, wdata_en,
    output rd_start_set, rd_end_set, rd_stop,
    output ram_rdata, snd_busy,
    input  ram_radr, ram_wadr, ram_wdata, ram_wen,
    input  read_sel, snd_data, snd_start, dump_running
`ifdef MON_DUMP_ADR_EN
    , input snd_adr
`endif
  );

  modport slave (
    input  cmd_data, cmd_ch, wadr_set, wdata_en,
    input  rd_start_set, rd_end_set, rd_stop,
    input  ram_rdata, snd_busy,
    output ram_radr, ram_wadr, ram_wdata, ram_wen,
    output read_sel, snd_data, snd_start, dump_running
`ifdef MON_DUMP_ADR_EN
    , output snd_adr
`endif
  );
endinterface

// File: rtl/uart_mon_mem_engine.sv
// Monitor memory engine: RAM writes and line-packed range dumps.
// Define MON_DUMP_ADR_EN to emit snd_adr with every dump line.
module uart_mon_mem_engine #(
  parameter int ADR_W  = 10,
  parameter int NCH    = 2,
  parameter int CH_W   = 1,
  parameter int RD_LAT = 1,
  parameter int LINE_W = 2
) (
  input logic                 clk,
  input logic                 rst,
  uart_mon_mem_engine_if.slave bus
);
  localparam int IDX_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WT, S_CAP, S_SND, S_HOLD
  } state_t;

  logic [ADR_W-1:0] w_cmd_adr;
  logic             w_unused;

  assign w_cmd_adr = bus.cmd_data[ADR_W+1:2];
  assign w_unused  = ^{bus.cmd_data[31:ADR_W+2],
                       bus.cmd_data[1:0]};

  // write path
  logic [ADR_W-1:0] r_wptr, w_wptr;
  logic [CH_W-1:0]  r_wch, w_wch;
  logic [ADR_W-1:0] r_wadr;
  logic [31:0]      r_wdata;
  logic [NCH-1:0]   r_wen;

  assign w_wptr = bus.wadr_set ? w_cmd_adr : r_wptr;
  assign w_wch  = bus.wadr_set ? bus.cmd_ch : r_wch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_wch   <= '0;
      r_wadr  <= '0;
      r_wdata <= '0;
      r_wen   <= '0;
    end else begin
      r_wen  <= '0;
      r_wptr <= w_wptr;
      r_wch  <= w_wch;
      if (bus.wdata_en) begin
        r_wptr  <= w_wptr + ADR_W'(1);
        r_wadr  <= w_wptr;
        r_wdata <= bus.cmd_data;
        for (int k = 0; k < NCH; k++)
          r_wen[k] <= (w_wch == CH_W'(k));
      end
    end
  end

  assign bus.ram_wadr  = r_wadr;
  assign bus.ram_wdata = r_wdata;
  assign bus.ram_wen   = r_wen;

  // dump path
  state_t                  r_state, w_nxt;
  logic [ADR_W-1:0]        r_st, r_end, r_cur, r_base;
  logic [CH_W-1:0]         r_sch, r_ch;
  logic [IDX_W-1:0]        r_idx;
  logic [1:0]              r_wcnt;
  logic                    r_last;
  logic [0:LINE_W-1][31:0] r_line;
  logic [0:LINE_W-1][31:0] r_snd_data;
  logic                    r_snd_start;
  logic [ADR_W+1:0]        r_snd_adr;

  logic        w_stop, w_launch, w_at_end, w_line_full;
  logic [31:0] w_rdata;

  assign w_stop      = bus.rd_stop && (r_state != S_IDLE);
  assign w_launch    = (r_state == S_IDLE) && bus.rd_end_set &&
                       !bus.rd_stop && (int'(r_sch) < NCH);
  // >= also covers end < start: the first word terminates the dump
  assign w_at_end    = (r_cur >= r_end);
  assign w_line_full = (r_idx == IDX_W'(LINE_W-1));
  assign w_rdata     = bus.ram_rdata[int'(r_ch)*32 +: 32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_launch) w_nxt = S_RD;
      S_RD:   w_nxt = (RD_LAT > 1) ? S_WT : S_CAP;
      S_WT:   if (r_wcnt == 2'(RD_LAT-2)) w_nxt = S_CAP;
      S_CAP:  w_nxt = (w_at_end || w_line_full) ? S_SND : S_RD;
      S_SND:  if (!bus.snd_busy) w_nxt = S_HOLD;
      S_HOLD: w_nxt = r_last ? S_IDLE : S_RD;
      default: w_nxt = S_IDLE;
    endcase
    if (w_stop) w_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st        <= '0;
      r_end       <= '0;
      r_cur       <= '0;
      r_base      <= '0;
      r_sch       <= '0;
      r_ch        <= '0;
      r_idx       <= '0;
      r_wcnt      <= '0;
      r_last      <= 1'b0;
      r_line      <= '0;
      r_snd_data  <= '0;
      r_snd_start <= 1'b0;
      r_snd_adr   <= '0;
    end else begin
      r_snd_start <= 1'b0;
      if (bus.rd_start_set) begin
        r_st  <= w_cmd_adr;
        r_sch <= bus.cmd_ch;
      end
      if (w_launch) begin
        r_end  <= w_cmd_adr;
        r_cur  <= r_st;
        r_base <= r_st;
        r_ch   <= r_sch;
        r_idx  <= '0;
        r_line <= '0;
      end
      if (!w_stop) begin
        unique case (r_state)
          S_RD: r_wcnt <= '0;
          S_WT: r_wcnt <= r_wcnt + 2'd1;
          S_CAP: begin
            r_line[r_idx] <= w_rdata;
            r_last        <= w_at_end;
            if (!(w_at_end || w_line_full)) begin
              r_cur <= r_cur + ADR_W'(1);
              r_idx <= r_idx + IDX_W'(1);
            end
          end
          S_SND: if (!bus.snd_busy) begin
            r_snd_start <= 1'b1;
            r_snd_data  <= r_line;
            r_snd_adr   <= {r_base, 2'b00};
          end
          S_HOLD: if (!r_last) begin
            r_cur  <= r_cur + ADR_W'(1);
            r_base <= r_cur + ADR_W'(1);
            r_idx  <= '0;
            r_line <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  logic [NCH-1:0] w_rsel;
  always_comb begin
    w_rsel = '0;
    for (int k = 0; k < NCH; k++)
      w_rsel[k] = (r_state != S_IDLE) && (r_ch == CH_W'(k));
  end

  assign bus.ram_radr     = r_cur;
  assign bus.read_sel     = w_rsel;
  assign bus.dump_running = (r_state != S_IDLE);
  assign bus.snd_start    = r_snd_start;
  assign bus.snd_data     = r_snd_data;
`ifdef MON_DUMP_ADR_EN
  assign bus.snd_adr      = r_snd_adr;
`else
  logic w_unused_adr;
  assign w_unused_adr = ^r_snd_adr;
`endif
endmodule

// File: tb/tb_uart_mon_mem_engine.sv
// Directed bench for uart_mon_mem_engine (RD_LAT=2, LINE_W=2).
// Two-channel RAM model with two-cycle read latency.
module tb_uart_mon_mem_engine;
  localparam int ADR_W  = 10;
  localparam int NCH    = 2;
  localparam int CH_W   = 1;
  localparam int RD_LAT = 2;
  localparam int LINE_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

  uart_mon_mem_engine_if #(
    .ADR_W(ADR_W), .NCH(NCH), .CH_W(CH_W), .LINE_W(LINE_W)
  ) bus ();

  uart_mon_mem_engine #(
    .ADR_W(ADR_W), .NCH(NCH), .CH_W(CH_W),
    .RD_LAT(RD_LAT), .LINE_W(LINE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] m0 [1024];
  logic [31:0] m1 [1024];
  logic [63:0] p1, p2;

  always @(posedge clk) begin
    if (bus.ram_wen[0]) m0[bus.ram_wadr] <= bus.ram_wdata;
    if (bus.ram_wen[1]) m1[bus.ram_wadr] <= bus.ram_wdata;
    p1 <= {m1[bus.ram_radr], m0[bus.ram_radr]};
    p2 <= p1;
  end
  assign bus.ram_rdata = p2;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [63:0] lines [$];
  logic [11:0] adrs [$];
  int          sel_bad;

  function automatic logic [63:0] line_at(input int i);
    return (i < lines.size()) ? lines[i] : 64'hx;
  endfunction

  task automatic launch(input logic [31:0] s, input logic [31:0] e);
    @(negedge clk);
    bus.rd_start_set = 1'b1;
    bus.cmd_data     = s;
    bus.cmd_ch       = 1'b0;
    @(negedge clk);
    bus.rd_start_set = 1'b0;
    bus.rd_end_set   = 1'b1;
    bus.cmd_data     = e;
    @(negedge clk);
    bus.rd_end_set   = 1'b0;
  endtask

  task automatic collect(input int maxc);
    lines.delete();
    adrs.delete();
    sel_bad = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (bus.snd_start) begin
        lines.push_back(bus.snd_data);
`ifdef MON_DUMP_ADR_EN
        adrs.push_back(bus.snd_adr);
`endif
      end
      if (!bus.dump_running) return;
      if (bus.read_sel !== 2'b01) sel_bad++;
    end
    check("dump_timeout", 1, 0);
  endtask

  int cnt;

  initial begin
    bus.cmd_data     = '0;
    bus.cmd_ch       = '0;
    bus.wadr_set     = 1'b0;
    bus.wdata_en     = 1'b0;
    bus.rd_start_set = 1'b0;
    bus.rd_end_set   = 1'b0;
    bus.rd_stop      = 1'b0;
    bus.snd_busy     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wen",   bus.ram_wen, 0);
    check("rst_sel",   bus.read_sel, 0);
    check("rst_run",   bus.dump_running, 0);
    check("rst_start", bus.snd_start, 0);
    check("rst_data",  bus.snd_data, 0);
    check("rst_radr",  bus.ram_radr, 0);
    check("rst_wadr",  bus.ram_wadr, 0);
    check("rst_wdata", bus.ram_wdata, 0);
    rst = 1'b0;

    // write to channel 1 at byte 0x10
    @(negedge clk);
    bus.wadr_set = 1'b1; bus.cmd_data = 32'h10; bus.cmd_ch = 1'b1;
    @(negedge clk);
    bus.wadr_set = 1'b0; bus.wdata_en = 1'b1;
    bus.cmd_data = 32'hDEADBEEF;
    @(negedge clk);
    check("w1_wen",  bus.ram_wen, 2'b10);
    check("w1_wadr", bus.ram_wadr, 4);
    check("w1_data", bus.ram_wdata, 32'hDEADBEEF);
    bus.cmd_data = 32'h12345678;
    @(negedge clk);
    bus.wdata_en = 1'b0;
    check("w2_wen",  bus.ram_wen, 2'b10);
    check("w2_wadr", bus.ram_wadr, 5);
    check("w2_data", bus.ram_wdata, 32'h12345678);
    @(negedge clk);
    check("w_idle", bus.ram_wen, 0);

    // channel 0 words 0..3 = 1..4
    bus.wadr_set = 1'b1; bus.cmd_data = 0; bus.cmd_ch = 1'b0;
    @(negedge clk);
    bus.wadr_set = 1'b0; bus.wdata_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.cmd_data = i;
      @(negedge clk);
    end
    bus.wdata_en = 1'b0;

    // same-cycle address load and write
    @(negedge clk);
    bus.wadr_set = 1'b1; bus.wdata_en = 1'b1;
    bus.cmd_data = 32'h20; bus.cmd_ch = 1'b0;
    @(negedge clk);
    bus.wadr_set = 1'b0; bus.wdata_en = 1'b0;
    check("sc_wen",  bus.ram_wen, 2'b01);
    check("sc_wadr", bus.ram_wadr, 8);
    check("sc_data", bus.ram_wdata, 32'h20);

    // pointer wrap on channel 1
    @(negedge clk);
    bus.wadr_set = 1'b1; bus.cmd_data = 32'hFFC; bus.cmd_ch = 1'b1;
    @(negedge clk);
    bus.wadr_set = 1'b0; bus.wdata_en = 1'b1;
    bus.cmd_data = 32'hAAAA0001;
    @(negedge clk);
    check("wr_top", bus.ram_wadr, 10'h3FF);
    bus.cmd_data = 32'hBBBB0002;
    @(negedge clk);
    bus.wdata_en = 1'b0;
    check("wr_wrap", bus.ram_wadr, 0);
    check("wr_wen",  bus.ram_wen, 2'b10);

    // full two-line dump
    launch(0, 32'hC);
    collect(200);
    check("d1_n",   lines.size(), 2);
    check("d1_l0",  line_at(0), 64'h00000001_00000002);
    check("d1_l1",  line_at(1), 64'h00000003_00000004);
    check("d1_sel", sel_bad, 0);
`ifdef MON_DUMP_ADR_EN
    check("d1_a0", (adrs.size() > 0) ? adrs[0] : 12'hxxx, 12'h000);
    check("d1_a1", (adrs.size() > 1) ? adrs[1] : 12'hxxx, 12'h008);
`endif

    // odd tail: three words
    launch(0, 32'h8);
    collect(200);
    check("d2_n",  lines.size(), 2);
    check("d2_l0", line_at(0), 64'h00000001_00000002);
    check("d2_l1", line_at(1), 64'h00000003_00000000);

    // back-pressure at SND
    bus.snd_busy = 1'b1;
    launch(0, 32'h4);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.snd_start) cnt++;
    end
    check("bp_held", cnt, 0);
    check("bp_run",  bus.dump_running, 1);
    bus.snd_busy = 1'b0;
    @(negedge clk);
    check("bp_start", bus.snd_start, 1);
    check("bp_data",  bus.snd_data, 64'h00000001_00000002);
    collect(50);
    check("bp_end", bus.dump_running, 0);

    // abort during WT of the second word
    launch(0, 32'hC);
    repeat (4) @(negedge clk);
    bus.rd_stop = 1'b1; bus.rd_end_set = 1'b1;
    @(negedge clk);
    bus.rd_stop = 1'b0; bus.rd_end_set = 1'b0;
    check("ab_run", bus.dump_running, 0);
    check("ab_sel", bus.read_sel, 0);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.snd_start || bus.dump_running) cnt++;
    end
    check("ab_quiet", cnt, 0);

    // end below start: only the start word
    launch(32'h20, 32'h10);
    collect(200);
    check("eb_n",  lines.size(), 1);
    check("eb_l0", line_at(0), 64'h00000020_00000000);
`ifdef MON_DUMP_ADR_EN
    check("eb_a0", (adrs.size() > 0) ? adrs[0] : 12'hxxx, 12'h020);
`endif

    // asynchronous reset in mid-dump
    launch(0, 32'hC);
    @(negedge clk);
    check("rm_pre", bus.dump_running, 1);
    #1 rst = 1'b1;
    #1;
    check("rm_run", bus.dump_running, 0);
    check("rm_sel", bus.read_sel, 0);
    check("rm_dat", bus.snd_data, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.snd_start || bus.dump_running) cnt++;
    end
    check("rm_quiet", cnt, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
